// File: rtl/int_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : int_sequencer
//  Purpose  : Interrupt entry/exit sequencer for a three-stage
//             fetch/decode/execute pipeline.
//             - Detects a rising edge on int_req.
//             - Drains the pipeline for DRAIN_CYCLES bubble cycles. The drain
//               count freezes while an execute hazard is present.
//             - Pushes the PC and then the flags through the memory stage.
//             - Jumps to the interrupt vector.
//             - On RTI, pops the flags and then the PC, and restores the PC
//               from the stack.
//
//  Parameters:
//    DRAIN_CYCLES  bubble cycles inserted before the PC push (0 = one cycle)
//
//  Ports:
//    clk          in   1  single clock, rising edge
//    rst          in   1  synchronous active-high reset
//    int_req      in   1  external interrupt line (edge detected)
//    hazard_i     in   1  execute-stage hazard, freezes the drain count
//    rti_i        in   1  RTI decoded (honoured only inside the ISR)
//    mem_ready_i  in   1  memory stage accepted the current stack op
//    fetch_stall  out  1  stall the fetch stage
//    flush_fd     out  1  flush the fetch->decode register
//    flush_de     out  1  flush the decode->execute register
//    pc_sel       out  2  00 sequential, 01 hold, 10 IVT vector, 11 restore
//    push_pc      out  1  stack push of the PC
//    push_flags   out  1  stack push of the flags
//    pop_flags    out  1  stack pop of the flags
//    pop_pc       out  1  stack pop of the PC
//    int_ack      out  1  interrupt acknowledge (vector cycle)
//    in_isr       out  1  the core is executing the service routine
//    busy         out  1  the sequencer owns the pipeline
//
//  Configuration macro:
//    INT_PENDING_EN  When defined, an event that arrives outside IDLE is
//                    held in a one-deep pending flag. That event is
//                    serviced straight from RESUME. When undefined, such
//                    events are dropped.
//
//  Revision : 1.0  initial release
// ============================================================================
module int_sequencer #(
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       int_req,
   input  logic       hazard_i,
   input  logic       rti_i,
   input  logic       mem_ready_i,
   output logic       fetch_stall,
   output logic       flush_fd,
   output logic       flush_de,
   output logic [1:0] pc_sel,
   output logic       push_pc,
   output logic       push_flags,
   output logic       pop_flags,
   output logic       pop_pc,
   output logic       int_ack,
   output logic       in_isr,
   output logic       busy
);

   // Counter must be able to hold DRAIN_CYCLES itself; keep at least 1 bit.
   localparam int unsigned CNT_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);

   localparam logic [1:0] PC_SEQ     = 2'b00;
   localparam logic [1:0] PC_HOLD    = 2'b01;
   localparam logic [1:0] PC_VECTOR  = 2'b10;
   localparam logic [1:0] PC_RESTORE = 2'b11;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_DRAIN    = 4'd1,
      S_PUSH_PC  = 4'd2,
      S_PUSH_FLG = 4'd3,
      S_VECTOR   = 4'd4,
      S_ISR      = 4'd5,
      S_POP_FLG  = 4'd6,
      S_POP_PC   = 4'd7,
      S_RESUME   = 4'd8
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] drain_cnt;
   logic [CNT_W-1:0] drain_cnt_nxt;
   logic             int_req_q;
   logic             req_event;
   logic             restart;     // RESUME goes straight back to DRAIN

   // The registered copy is cleared by reset. As a result, a line held high
   // across reset release is seen as a fresh edge in the first cycle.
   assign req_event = int_req & ~int_req_q;

`ifdef INT_PENDING_EN
   logic pending;
   logic pending_nxt;

   // The pending flag is consumed in RESUME. An edge that arrives in RESUME
   // itself is serviced directly rather than being parked, so it cannot be
   // stranded in the flag after the FSM has returned to IDLE.
   assign restart = (state == S_RESUME) && (pending || req_event);

   always_comb begin
      pending_nxt = pending;
      if (restart) begin
         pending_nxt = 1'b0;
      end else if (req_event && (state != S_IDLE)) begin
         // One-deep: once set, further edges change nothing.
         pending_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= 1'b0;
      end else begin
         pending <= pending_nxt;
      end
   end
`else
   assign restart = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // State, drain counter and edge-detect registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         drain_cnt <= '0;
         int_req_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_cnt_nxt;
         int_req_q <= int_req;
      end
   end

   // ------------------------------------------------------------------------
   // Next state, drain count and Moore outputs
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt     = state;
      drain_cnt_nxt = drain_cnt;
      fetch_stall   = 1'b0;
      flush_fd      = 1'b0;
      flush_de      = 1'b0;
      pc_sel        = PC_SEQ;
      push_pc       = 1'b0;
      push_flags    = 1'b0;
      pop_flags     = 1'b0;
      pop_pc        = 1'b0;
      int_ack       = 1'b0;
      in_isr        = 1'b0;
      busy          = 1'b1;

      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (req_event) begin
               state_nxt     = S_DRAIN;
               drain_cnt_nxt = DRAIN_LOAD;
            end
         end

         S_DRAIN: begin
            fetch_stall = 1'b1;
            flush_fd    = 1'b1;
            pc_sel      = PC_HOLD;
            // The cycle in which the count reads zero is the last drain cycle.
            // As a result, DRAIN_CYCLES = N gives N + 1 drain cycles.
            if (drain_cnt == '0) begin
               state_nxt = S_PUSH_PC;
            end else if (!hazard_i) begin
               drain_cnt_nxt = drain_cnt - CNT_W'(1);
            end
         end

         S_PUSH_PC: begin
            fetch_stall = 1'b1;
            pc_sel      = PC_HOLD;
            push_pc     = 1'b1;
            if (mem_ready_i) begin
               state_nxt = S_PUSH_FLG;
            end
         end

         S_PUSH_FLG: begin
            fetch_stall = 1'b1;
            pc_sel      = PC_HOLD;
            push_flags  = 1'b1;
            if (mem_ready_i) begin
               state_nxt = S_VECTOR;
            end
         end

         S_VECTOR: begin
            pc_sel    = PC_VECTOR;
            int_ack   = 1'b1;
            flush_fd  = 1'b1;
            flush_de  = 1'b1;
            state_nxt = S_ISR;
         end

         S_ISR: begin
            busy   = 1'b0;
            in_isr = 1'b1;
            if (rti_i) begin
               state_nxt = S_POP_FLG;
            end
         end

         S_POP_FLG: begin
            fetch_stall = 1'b1;
            pc_sel      = PC_HOLD;
            pop_flags   = 1'b1;
            if (mem_ready_i) begin
               state_nxt = S_POP_PC;
            end
         end

         S_POP_PC: begin
            fetch_stall = 1'b1;
            pc_sel      = PC_HOLD;
            pop_pc      = 1'b1;
            if (mem_ready_i) begin
               state_nxt = S_RESUME;
            end
         end

         S_RESUME: begin
            pc_sel   = PC_RESTORE;
            flush_fd = 1'b1;
            flush_de = 1'b1;
            if (restart) begin
               state_nxt     = S_DRAIN;
               drain_cnt_nxt = DRAIN_LOAD;
            end else begin
               state_nxt = S_IDLE;
            end
         end

         default: begin
            busy      = 1'b0;
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: doc/int_sequencer.md
INT_SEQUENCER -- requirements
Module: int_sequencer

Interface
REQ-001 SHALL have parameter: DRAIN_CYCLES, 3, bubble cycles to empty fetch/decode/execute before the PC push.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: int_req input 1 external interrupt line; hazard_i input 1 execute-stage hazard (drain counter frozen while high); rti_i input 1 RTI decoded; mem_ready_i input 1 memory stage accepted current stack op.
REQ-005 SHALL have ports: fetch_stall output 1; flush_fd output 1; flush_de output 1; pc_sel output 2 (00 sequential, 01 hold, 10 IVT vector, 11 restore from stack); push_pc, push_flags, pop_flags, pop_pc output 1 each; int_ack output 1; in_isr output 1; busy output 1.

Function
REQ-006 SHALL detect request event = int_req high and int_req registered copy low (rising edge, registered copy updated every cycle).
REQ-007 SHALL implement states IDLE, DRAIN, PUSH_PC, PUSH_FLG, VECTOR, ISR, POP_FLG, POP_PC, RESUME; busy=1 in every state except IDLE and ISR.
REQ-008 IDLE: all outputs 0, pc_sel=00; on event -> DRAIN, drain counter loaded with DRAIN_CYCLES.
REQ-009 DRAIN: fetch_stall=1, flush_fd=1, pc_sel=01; counter decrements when hazard_i=0, holds when hazard_i=1; transition to PUSH_PC in the cycle after counter reads 0.
REQ-010 PUSH_PC: push_pc=1, pc_sel=01, fetch_stall=1; held until mem_ready_i=1, then -> PUSH_FLG.
REQ-011 PUSH_FLG: push_flags=1, pc_sel=01, fetch_stall=1; held until mem_ready_i=1, then -> VECTOR.
REQ-012 VECTOR: exactly one cycle; pc_sel=10, int_ack=1, flush_fd=1, flush_de=1; -> ISR.
REQ-013 ISR: in_isr=1, other outputs 0; request events not serviced; rti_i=1 -> POP_FLG.
REQ-014 POP_FLG: pop_flags=1, fetch_stall=1, pc_sel=01 until mem_ready_i=1 -> POP_PC; POP_PC: pop_pc=1, same rules -> RESUME.
REQ-015 RESUME: exactly one cycle; pc_sel=11, flush_fd=1, flush_de=1; -> IDLE.
REQ-016 rti_i outside ISR SHALL be ignored; mem_ready_i outside push/pop states SHALL be ignored.
REQ-017 push/pop strobes SHALL be mutually exclusive and at most one asserted per cycle.
REQ-018 DRAIN_CYCLES=0 SHALL make DRAIN last exactly one cycle.

Reset
REQ-019 rst=1 SHALL force IDLE in the next cycle from any state, clear drain counter, pending flag and int_req registered copy to 0; all outputs 0, pc_sel=00.
REQ-020 int_req held high across reset release SHALL count as one event in the first cycle after reset.

Configuration
REQ-021 Macro INT_PENDING_EN defined: an event arriving in any state other than IDLE sets a one-deep pending flag (further events while set are dropped); on RESUME->IDLE with pending set, FSM goes directly RESUME->DRAIN instead, clearing the flag.
REQ-022 INT_PENDING_EN undefined: events outside IDLE are discarded; no pending storage exists.

Verification
REQ-023 int_req 0->1, hazard_i=0, mem_ready_i=1 -> DRAIN 4 cycles (DRAIN_CYCLES=3), push_pc 1 cycle, push_flags 1 cycle, int_ack with pc_sel=10 at cycle 7 after event, in_isr=1 from cycle 8.
REQ-024 hazard_i high 2 cycles during DRAIN -> push_pc delayed exactly 2 cycles versus REQ-023.
REQ-025 mem_ready_i low 3 cycles during PUSH_PC -> push_pc held 4 cycles, push_flags not asserted until after.
REQ-026 In ISR pulse rti_i -> pop_flags, pop_pc, then one cycle pc_sel=11 with flush_fd=flush_de=1, then IDLE; rti_i in IDLE -> no output change.
REQ-027 Second int_req edge during ISR -> with INT_PENDING_EN: DRAIN entered immediately after RESUME; without: returns to IDLE, no second int_ack.
REQ-028 rst asserted during PUSH_FLG -> next cycle all outputs 0, IDLE; int_req kept high -> new event serviced after release.
